csr_file_m: RTL

//  Parametrised M-mode CSR unit for the NPC core. It generalises the fixed 64-bit CSR set to XLEN bits.

---
 rtl/csr_pkg.sv | 36 +++
 rtl/csr_file_m_irq_arb.sv | 21 ++
 rtl/csr_file_m.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared CSR addresses, cause codes and op encodings for the M-mode CSR unit.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;
  localparam logic [3:0] ECALL_M = 4'd11;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MHARTID: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_m_irq_arb.sv
// Fixed-priority interrupt arbiter: MEI > MSI > MTI, gated by mstatus.MIE.
module csr_irq_arb
  import csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pend,
  input  logic            mie,
  output logic            take,
  output logic [3:0]      code
);

  always_comb begin
    take = mie & (|pend);
    code = 4'd0;
    if (pend[IRQ_MEI])      code = IRQ_MEI;
    else if (pend[IRQ_MSI]) code = IRQ_MSI;
    else if (pend[IRQ_MTI]) code = IRQ_MTI;
  end

endmodule

// File: rtl/csr_file_m.sv
// M-mode CSR file: atomic CSR ops, trap/mret sequencing, counters and
// level-sensitive interrupt capture with direct/vectored mtvec.
module csr_file_m
  import csr_pkg::*;
#(
  parameter int          XLEN        = 64,
  parameter bit          VECTORED_EN = 1'b1,
  parameter logic [63:0] MSTATUS_RST = 64'ha00001800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic            csr_src_zero,
  input  logic [XLEN-1:0] csr_wsrc,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic            instret_inc,
  input  logic            irq_msip,
  input  logic            irq_mtip,
  input  logic            irq_meip,
  output logic            irq_take,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mret_pc
);

  localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);
  localparam logic [XLEN-1:0] LSB_CLR  = ~XLEN'(1);

  logic [XLEN-1:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q;
  logic [XLEN-1:0] mcause_q, mtval_q, mip_q, mcycle_q, minstret_q;
  logic [XLEN-1:0] mstatus_rd, mip_next, wval, trap_cause, vec_base;
  logic            suppress, csr_we, arb_take;
  logic [3:0]      irq_code;
  logic [1:0]      mtvec_mode;
  csr_op_e         op;

  assign op = csr_op_e'(csr_op);

  csr_irq_arb #(.XLEN(XLEN)) u_irq_arb (
    .pend (mip_q & mie_q),
    .mie  (mstatus_q[3]),
    .take (arb_take),
    .code (irq_code)
  );

  assign irq_take = arb_take & ~exc_valid & ~mret;
  assign mret_pc  = mepc_q;

  always_comb begin
    mstatus_rd        = mstatus_q;
    mstatus_rd[12:11] = 2'b11;
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus_rd;
      CSR_MIE:      csr_rdata = mie_q;
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MTVAL:    csr_rdata = mtval_q;
      CSR_MIP:      csr_rdata = mip_q;
      CSR_MCYCLE:   csr_rdata = mcycle_q;
      CSR_MINSTRET: csr_rdata = minstret_q;
      default:      csr_rdata = '0;
    endcase
  end

  // Read-only space is only an error when the access would actually write.
  always_comb begin
    suppress    = ((op == CSR_OP_RS) || (op == CSR_OP_RC)) && csr_src_zero;
    csr_illegal = (op != CSR_OP_NONE) &&
                  (!csr_implemented(csr_addr) || ((csr_addr[11:10] == 2'b11) && !suppress));
    csr_we      = (op != CSR_OP_NONE) && !csr_illegal && !suppress &&
                  !exc_valid && !irq_take && !mret;
    case (op)
      CSR_OP_RW: wval = csr_wsrc;
      CSR_OP_RS: wval = csr_rdata | csr_wsrc;
      CSR_OP_RC: wval = csr_rdata & ~csr_wsrc;
      default:   wval = csr_rdata;
    endcase
    mtvec_mode = ((wval[1:0] == 2'b01) && VECTORED_EN) ? 2'b01 : 2'b00;
  end

  always_comb begin
    mip_next          = '0;
    mip_next[IRQ_MSI] = irq_msip;
    mip_next[IRQ_MTI] = irq_mtip;
    mip_next[IRQ_MEI] = irq_meip;
    trap_cause        = exc_valid ? exc_cause : {1'b1, {(XLEN-5){1'b0}}, irq_code};
    vec_base          = {mtvec_q[XLEN-1:2], 2'b00};
    trap_vector       = vec_base;
    if (irq_take && (mtvec_q[1:0] == 2'b01))
      trap_vector = vec_base + XLEN'({irq_code, 2'b00});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= MSTATUS_RST[XLEN-1:0];
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mip_q      <= mip_next;
      mcycle_q   <= mcycle_q + XLEN'(1);
      minstret_q <= minstret_q + XLEN'(instret_inc);
      if (exc_valid || irq_take) begin
        mepc_q       <= exc_pc & LSB_CLR;
        mcause_q     <= trap_cause;
        mtval_q      <= exc_valid ? exc_tval : '0;
        mstatus_q[7] <= mstatus_q[3];
        mstatus_q[3] <= 1'b0;
      end else if (mret) begin
        mstatus_q[3] <= mstatus_q[7];
        mstatus_q[7] <= 1'b1;
      end else if (csr_we) begin
        // Later assignments here intentionally override the counter increments.
        case (csr_addr)
          CSR_MSTATUS: begin
            mstatus_q[3] <= wval[3];
            mstatus_q[7] <= wval[7];
          end
          CSR_MIE:      mie_q      <= wval & MIE_MASK;
          CSR_MTVEC:    mtvec_q    <= {wval[XLEN-1:2], mtvec_mode};
          CSR_MSCRATCH: mscratch_q <= wval;
          CSR_MEPC:     mepc_q     <= wval & LSB_CLR;
          CSR_MCAUSE:   mcause_q   <= wval;
          CSR_MTVAL:    mtval_q    <= wval;
          CSR_MCYCLE:   mcycle_q   <= wval;
          CSR_MINSTRET: minstret_q <= wval;
          default: ;
        endcase
      end
    end
  end

endmodule
